// File: rtl/led_fader.sv
// rtl/led_fader.sv - Pattern-driven LED fader with linear brightness ramps and PWM output.
// Optional gamma curve on the PWM compare value: define LED_FADER_GAMMA_EN.
module led_fader #(
    parameter int NUM_LEDS = 8,
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_LEDS-1:0] pattern_in,
    input  logic                pattern_valid,
    output logic                pattern_ready,
    input  logic [PWM_BITS-1:0] max_level,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                busy
);

    localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_DIV - 1);
    localparam logic [PWM_BITS-1:0] LVL_MAX  = '1;
    // PWM counter stops one short of all-ones so a full-scale level is constantly on.
    localparam logic [PWM_BITS-1:0] PWM_TOP  = LVL_MAX - 1'b1;

    typedef enum logic {
        ST_IDLE,
        ST_FADING
    } state_t;

    state_t              r_state;
    logic                r_ready;
    logic                r_busy;
    logic [NUM_LEDS-1:0] r_led;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PRE_W-1:0]    r_pre;
    logic [PWM_BITS-1:0] r_level  [NUM_LEDS];
    logic [PWM_BITS-1:0] r_target [NUM_LEDS];

    logic                w_step_tick;
    logic                w_all_done;
    logic                w_accept;
    logic [PWM_BITS-1:0] w_eff [NUM_LEDS];

    assign w_step_tick   = (r_pre == PRE_LAST);
    assign w_accept      = (r_state == ST_IDLE) && r_ready && pattern_valid;
    assign pattern_ready = r_ready;
    assign busy          = r_busy;
    assign led_out       = r_led;

    always_comb begin
        w_all_done = 1'b1;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (r_level[i] != r_target[i]) begin
                w_all_done = 1'b0;
            end
        end
    end

`ifdef LED_FADER_GAMMA_EN
    logic [2*PWM_BITS-1:0] w_sq [NUM_LEDS];

    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            w_sq[i] = (2*PWM_BITS)'(r_level[i]) * (2*PWM_BITS)'(r_level[i]);
            if (r_level[i] == LVL_MAX) begin
                w_eff[i] = LVL_MAX;
            end else begin
                w_eff[i] = PWM_BITS'(w_sq[i] >> PWM_BITS);
            end
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            w_eff[i] = r_level[i];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= '0;
            r_pre     <= '0;
        end else begin
            r_pwm_cnt <= (r_pwm_cnt == PWM_TOP) ? '0 : r_pwm_cnt + 1'b1;
            r_pre     <= (r_pre == PRE_LAST) ? '0 : r_pre + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= '0;
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                r_led[i] <= (w_eff[i] > r_pwm_cnt);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                r_level[i]  <= '0;
                r_target[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_busy <= 1'b0;
                    if (w_accept) begin
                        for (int i = 0; i < NUM_LEDS; i++) begin
                            r_target[i] <= pattern_in[i] ? max_level : '0;
                        end
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_FADING;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                ST_FADING: begin
                    // Completion is judged on the registered levels, so a no-op fade still spends one cycle here.
                    if (w_all_done) begin
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_step_tick) begin
                        for (int i = 0; i < NUM_LEDS; i++) begin
                            if (r_level[i] < r_target[i]) begin
                                r_level[i] <= r_level[i] + 1'b1;
                            end else if (r_level[i] > r_target[i]) begin
                                r_level[i] <= r_level[i] - 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_fader.sv
// tb/tb_led_fader.sv - Directed bench for led_fader (STEP_DIV=4 and STEP_DIV=1 instances).
`timescale 1ns/1ps
module tb_led_fader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pat4, max4, pat1, max1;
    logic       val4, val1;
    logic       rdy4, busy4, rdy1, busy1;
    logic [7:0] led4, led1;

    int total = 0;
    int bad   = 0;
    int hc [8];
    int n;
    int guard;

    always #5 clk = ~clk;

    led_fader #(.NUM_LEDS(8), .PWM_BITS(8), .STEP_DIV(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .pattern_in(pat4), .pattern_valid(val4),
        .pattern_ready(rdy4), .max_level(max4), .led_out(led4), .busy(busy4)
    );

    led_fader #(.NUM_LEDS(8), .PWM_BITS(8), .STEP_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .pattern_in(pat1), .pattern_valid(val1),
        .pattern_ready(rdy1), .max_level(max1), .led_out(led1), .busy(busy1)
    );

    function automatic int gam(input int l);
`ifdef LED_FADER_GAMMA_EN
        if (l == 255) return 255;
        return (l * l) >> 8;
`else
        return l;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic accept(input bit sel, input logic [7:0] pat, input logic [7:0] mx);
        int k = 0;
        while (!(sel ? rdy1 : rdy4) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("ready_before_accept", sel ? rdy1 : rdy4, 1);
        if (sel) begin pat1 = pat; max1 = mx; val1 = 1'b1; end
        else     begin pat4 = pat; max4 = mx; val4 = 1'b1; end
        @(negedge clk);
        val1 = 1'b0;
        val4 = 1'b0;
    endtask

    task automatic wait_idle(input bit sel, output int cyc);
        cyc = 0;
        while ((sel ? busy1 : busy4) && cyc < 2000) begin
            cyc++;
            @(negedge clk);
        end
        check("fade_timeout", sel ? busy1 : busy4, 0);
        check("ready_after_fade", sel ? rdy1 : rdy4, 1);
    endtask

    task automatic measure(input bit sel);
        for (int i = 0; i < 8; i++) hc[i] = 0;
        repeat (255) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) hc[i] += int'(sel ? led1[i] : led4[i]);
        end
    endtask

    task automatic check_counts(input string tag, input logic [7:0] on_mask, input int lvl);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_led%0d", tag, i), hc[i], on_mask[i] ? gam(lvl) : 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        val4 = 1'b0; val1 = 1'b0;
        pat4 = '0; max4 = '0; pat1 = '0; max1 = '0;
        repeat (3) @(negedge clk);
        check("rst_led4", led4, 0);
        check("rst_busy4", busy4, 0);
        check("rst_ready4", rdy4, 0);
        check("rst_ready1", rdy1, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready4", rdy4, 1);
        check("post_rst_ready1", rdy1, 1);
        check("post_rst_busy4", busy4, 0);

        // A5 at level 4 with STEP_DIV=4: 4 ticks plus prescaler phase
        accept(0, 8'hA5, 8'd4);
        wait_idle(0, n);
        check("a5_busy_len_in_14_17", (n >= 14 && n <= 17), 1);
        measure(0);
        check_counts("a5", 8'hA5, 4);

        // pattern_valid held during FADING must not retarget
        accept(0, 8'h3C, 8'd2);
        repeat (5) begin
            pat4 = 8'h0F; max4 = 8'd9; val4 = 1'b1;
            @(negedge clk);
            check("fading_ready_low", rdy4, 0);
            check("fading_busy_high", busy4, 1);
        end
        val4 = 1'b0;
        wait_idle(0, n);
        measure(0);
        check_counts("ignore_valid", 8'h3C, 2);

        // same targets as current levels: one FADING cycle
        accept(0, 8'h3C, 8'd2);
        wait_idle(0, n);
        check("noop_busy_len", n, 1);

        // STEP_DIV=1 full-scale ramp up and down
        accept(1, 8'hFF, 8'd255);
        wait_idle(1, n);
        check("ff_busy_len", n, 256);
        measure(1);
        check_counts("full_on", 8'hFF, 255);
        accept(1, 8'h00, 8'd255);
        wait_idle(1, n);
        check("off_busy_len", n, 256);
        measure(1);
        check_counts("full_off", 8'h00, 0);

        accept(1, 8'hFF, 8'd16);
        wait_idle(1, n);
        check("l16_busy_len", n, 17);
        measure(1);
        check_counts("l16", 8'hFF, 16);
        accept(1, 8'hAA, 8'd0);
        wait_idle(1, n);
        check("max0_busy_len", n, 17);
        measure(1);
        check_counts("max0", 8'h00, 0);

        // asynchronous reset in the middle of a fade toward 200
        accept(0, 8'hC3, 8'd200);
        guard = 0;
        while (led4 == 8'h00 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("midfade_led_seen", (led4 != 8'h00), 1);
        check("midfade_busy", busy4, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_led4", led4, 0);
        check("async_rst_busy4", busy4, 0);
        check("async_rst_ready4", rdy4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_rst_ready4", rdy4, 1);
        measure(0);
        check_counts("not_resumed", 8'h00, 0);
        check("not_resumed_busy", busy4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
